// File: rtl/ucie_ctl_phy_tx_datapath.sv
// ucie_ctl_phy_tx_datapath: RDI mainband TX path, adapter words -> FIFO -> partner RX, gated by RDI state
// Ports: i_clk/i_rst (async, active-high); i_rdi_pl_state_sts RDI state; i_rdi_lp_irdy/i_rdi_lp_valid/
//   i_rdi_lp_data with o_rdi_pl_trdy adapter handshake; i_link_ready partner RX ready; i_phy_req_data_error
//   corrupt-next-word pulse; o_data_sent/o_data_valid word out; o_fifo_empty; o_tx_count sent words.
module ucie_ctl_phy_tx_datapath #(
    parameter int NBYTES     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [3:0]            i_rdi_pl_state_sts,
    input  logic                  i_rdi_lp_irdy,
    input  logic                  i_rdi_lp_valid,
    input  logic [NBYTES*8-1:0]   i_rdi_lp_data,
    output logic                  o_rdi_pl_trdy,
    input  logic                  i_link_ready,
    input  logic                  i_phy_req_data_error,
    output logic [NBYTES*8-1:0]   o_data_sent,
    output logic                  o_data_valid,
    output logic                  o_fifo_empty,
    output logic [CNT_W-1:0]      o_tx_count
);
    localparam int DW = NBYTES * 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
    state_t state, state_nxt;
    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [OW-1:0] occ;
    logic err_flag, full, empty, push, pop, flush, corrupt;
    logic sts_act, sts_stop, sts_kill;
    assign sts_act  = i_rdi_pl_state_sts == 4'b0001;
    assign sts_stop = i_rdi_pl_state_sts == 4'b1011 || i_rdi_pl_state_sts == 4'b0000;
    assign sts_kill = i_rdi_pl_state_sts inside {4'b1001, 4'b1010, 4'b1100};
    assign flush    = state != IDLE && sts_kill;
    assign empty    = occ == '0;
    assign full     = occ == OW'(FIFO_DEPTH);
    assign push     = o_rdi_pl_trdy && i_rdi_lp_irdy && i_rdi_lp_valid;
    // a flushing cycle sends nothing: the queued words are being discarded
    assign pop      = state != IDLE && !empty && i_link_ready && !flush;
    assign corrupt  = pop && (err_flag || i_phy_req_data_error);
    assign o_fifo_empty = empty;
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = sts_act ? ACTIVE : IDLE;
            ACTIVE:  state_nxt = sts_kill ? IDLE : sts_stop ? DRAIN : ACTIVE;
            DRAIN:   state_nxt = sts_kill ? IDLE : sts_act ? ACTIVE : empty ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end
    // registered state and occupancy only, so trdy never depends on lp_* this cycle
    always_comb o_rdi_pl_trdy = state == ACTIVE && !full;
    always_ff @(posedge i_clk)
        if (push) mem[wr_ptr] <= i_rdi_lp_data;
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            occ          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            err_flag     <= 1'b0;
            o_data_sent  <= '0;
            o_data_valid <= 1'b0;
            o_tx_count   <= '0;
        end else begin
            if (flush) begin
                occ    <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                occ    <= occ + OW'(push) - OW'(pop);
                wr_ptr <= wr_ptr + AW'(push);
                rd_ptr <= rd_ptr + AW'(pop);
            end
            // the request is consumed by the pop it coincides with, otherwise it waits
            err_flag     <= pop ? 1'b0 : err_flag || i_phy_req_data_error;
            o_data_valid <= pop;
            if (pop) begin
                o_data_sent <= mem[rd_ptr] ^ DW'(corrupt);
                o_tx_count  <= o_tx_count + 1'b1;
            end
        end
endmodule

// File: tb/tb_ucie_ctl_phy_tx_datapath.sv
// tb_ucie_ctl_phy_tx_datapath: directed scenarios plus random traffic against a queue-based reference
module tb_ucie_ctl_phy_tx_datapath;
    localparam int DEPTH = 4;
    localparam int M_IDLE = 0, M_ACT = 1, M_DRAIN = 2;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sts;
    logic        irdy, vld, lr, req;
    logic [63:0] din;
    logic        trdy, dvalid, fempty;
    logic [63:0] dsent;
    logic [15:0] cnt;
    int n_checks = 0, n_fail = 0;
    logic [63:0] q [$];
    int          mode;
    bit          err_m, exp_valid, last_push;
    logic [63:0] exp_sent;
    logic [15:0] exp_cnt;
    ucie_ctl_phy_tx_datapath dut (
        .i_clk(clk), .i_rst(rst), .i_rdi_pl_state_sts(sts),
        .i_rdi_lp_irdy(irdy), .i_rdi_lp_valid(vld), .i_rdi_lp_data(din),
        .o_rdi_pl_trdy(trdy), .i_link_ready(lr), .i_phy_req_data_error(req),
        .o_data_sent(dsent), .o_data_valid(dvalid), .o_fifo_empty(fempty), .o_tx_count(cnt)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        q.delete();
        mode = M_IDLE;
        err_m = 0;
        exp_valid = 0;
        exp_sent = '0;
        exp_cnt = '0;
    endtask
    task automatic check_reset_values(input string tag);
        check({tag, "_trdy"}, trdy, 0);
        check({tag, "_valid"}, dvalid, 0);
        check({tag, "_sent"}, dsent, 0);
        check({tag, "_empty"}, fempty, 1);
        check({tag, "_cnt"}, cnt, 0);
    endtask
    task automatic cycle(input logic [3:0] s, input bit ir, input bit v, input bit l, input bit e,
                         input logic [63:0] d);
        bit kill, etrdy, flushing, popping, was_empty;
        logic [63:0] w;
        sts = s; irdy = ir; vld = v; lr = l; req = e; din = d;
        #1;
        kill      = s inside {4'h9, 4'hA, 4'hC};
        etrdy     = mode == M_ACT && q.size() < DEPTH;
        check("trdy", trdy, etrdy);
        last_push = etrdy && ir && v;
        flushing  = mode != M_IDLE && kill;
        popping   = mode != M_IDLE && q.size() != 0 && l && !flushing;
        was_empty = q.size() == 0;
        exp_valid = popping;
        if (popping) begin
            w = q.pop_front();
            if (err_m || e) w[0] = ~w[0];
            err_m = 0;
            exp_sent = w;
            exp_cnt++;
        end else if (e) err_m = 1;
        if (flushing) q.delete();
        else if (last_push) q.push_back(d);
        if (mode == M_IDLE) mode = (s == 4'h1) ? M_ACT : M_IDLE;
        else if (kill) mode = M_IDLE;
        else if (mode == M_ACT) mode = (s == 4'hB || s == 4'h0) ? M_DRAIN : M_ACT;
        else mode = (s == 4'h1) ? M_ACT : was_empty ? M_IDLE : M_DRAIN;
        @(posedge clk);
        #1;
        check("valid", dvalid, exp_valid);
        if (exp_valid) check("sent", dsent, exp_sent);
        check("empty", fempty, q.size() == 0);
        check("count", cnt, exp_cnt);
    endtask
    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction
    initial begin
        int pushes;
        logic [3:0] s;
        logic [3:0] sts_pool [8];
        sts_pool = '{4'h1, 4'h1, 4'h1, 4'hB, 4'h0, 4'h9, 4'hA, 4'hC};
        rst = 1; sts = 0; irdy = 0; vld = 0; lr = 0; req = 0; din = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 0;
        // bring-up: 20 words straight through
        cycle(4'h1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) cycle(4'h1, 1, 1, 1, 0, rnd64());
        cycle(4'h1, 0, 0, 1, 0, 0);
        check("t1_count", cnt, 16'd20);
        check("t1_empty", fempty, 1);
        // one push then observe: valid the cycle after the next edge
        cycle(4'h1, 1, 1, 1, 0, 64'h1234_5678_9abc_def0);
        check("t1_not_yet", dvalid, 0);
        cycle(4'h1, 0, 0, 1, 0, 0);
        check("t1_latency", dvalid, 1);
        check("t1_latency_data", dsent, 64'h1234_5678_9abc_def0);
        // backpressure: exactly DEPTH words accepted
        pushes = 0;
        for (int i = 0; i < 7; i++) begin
            cycle(4'h1, 1, 1, 0, 0, rnd64());
            pushes += int'(last_push);
        end
        check("t2_pushes", pushes, DEPTH);
        check("t2_full_trdy", trdy, 0);
        cycle(4'h1, 0, 0, 1, 0, 0);
        check("t2_trdy_back", trdy, 1);
        for (int i = 0; i < 4; i++) cycle(4'h1, 0, 0, 1, 0, 0);
        // handshake halves alone do not push
        cycle(4'h1, 1, 0, 0, 0, rnd64());
        cycle(4'h1, 0, 1, 0, 0, rnd64());
        check("t2_half_hs", fempty, 1);
        // retrain drains then idles
        for (int i = 0; i < 3; i++) cycle(4'h1, 1, 1, 0, 0, rnd64());
        cycle(4'hB, 1, 1, 0, 0, rnd64());
        check("t3_trdy", trdy, 0);
        for (int i = 0; i < 5; i++) cycle(4'hB, 1, 1, 1, 0, rnd64());
        check("t3_empty", fempty, 1);
        check("t3_idle", trdy, 0);
        // link error flushes
        cycle(4'h1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(4'h1, 1, 1, 0, 0, rnd64());
        cycle(4'hA, 0, 0, 0, 0, 0);
        check("t4_flushed", fempty, 1);
        for (int i = 0; i < 4; i++) cycle(4'hA, 0, 0, 1, 0, 0);
        check("t4_count", cnt, 16'd29);
        // error injection hits exactly one word
        cycle(4'h1, 0, 0, 0, 1, 0);
        cycle(4'h1, 1, 1, 1, 0, 64'h00FF_00FF_00FF_00FF);
        cycle(4'h1, 1, 1, 1, 0, 64'h00FF_00FF_00FF_00FF);
        check("t5_corrupt", dsent, 64'h00FF_00FF_00FF_00FE);
        cycle(4'h1, 0, 0, 1, 0, 0);
        check("t5_clean", dsent, 64'h00FF_00FF_00FF_00FF);
        // async reset mid-cycle with words queued
        for (int i = 0; i < 2; i++) cycle(4'h1, 1, 1, 0, 0, rnd64());
        #2 rst = 1;
        #1;
        check_reset_values("t6_async");
        @(posedge clk);
        #1 rst = 0;
        model_reset();
        cycle(4'h1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) cycle(4'h1, 1, 1, 1, 0, rnd64());
        cycle(4'h1, 0, 0, 1, 0, 0);
        check("t6_count", cnt, 16'd6);
        // random traffic
        s = 4'h1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) s = sts_pool[$urandom_range(0, 7)];
            cycle(s, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0, rnd64());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
